// File: rtl/dpll_lock_ctrl_if.sv
// Bundle of the loop controller's pulse and status signals.
// The master side (phase detector / test driver) drives en_i, lead_i, lag_i
// and edge_i. The slave side (dpll_lock_ctrl) drives the DCO requests and
// the lock/holdover status.
//   en_i       loop enable
//   lead_i     reference-leads pulse from the phase detector
//   lag_i      reference-lags pulse from the phase detector
//   edge_i     one pulse per input data transition
//   carry_o    one-cycle add request to the DCO
//   sub_o      one-cycle subtract request to the DCO
//   lock_o     loop is locked
//   hold_o     loop is in holdover
//   state_o    IDLE=0, ACQ=1, LOCK=2, HOLD=3
//   win_err_o  error count of the last completed window
interface dpll_lock_ctrl_if #(
    parameter int WIN = 64
);
    logic                       en_i;
    logic                       lead_i;
    logic                       lag_i;
    logic                       edge_i;
    logic                       carry_o;
    logic                       sub_o;
    logic                       lock_o;
    logic                       hold_o;
    logic [1:0]                 state_o;
    logic [$clog2(WIN+1)-1:0]   win_err_o;

    modport master (
        output en_i, lead_i, lag_i, edge_i,
        input  carry_o, sub_o, lock_o, hold_o, state_o, win_err_o
    );

    modport slave (
        input  en_i, lead_i, lag_i, edge_i,
        output carry_o, sub_o, lock_o, hold_o, state_o, win_err_o
    );
endinterface

// File: rtl/dpll_lock_ctrl.sv
// Loop controller for the DPSK bit-sync DPLL.
// A random-walk filter turns lead/lag pulses into DCO carry/subtract
// requests, using a small threshold while acquiring and a large one while
// locked. Error density per window of WIN input edges decides lock entry and
// loss; a silence timeout freezes the loop (holdover) until edges return.
// Ports:
//   clk1   core clock
//   rst_i  synchronous active-high reset
//   bus    dpll_lock_ctrl_if slave: en/lead/lag/edge in, carry/sub/lock/
//          hold/state/win_err out
module dpll_lock_ctrl #(
    parameter int N_ACQ        = 4,
    parameter int N_TRK        = 16,
    parameter int WIN          = 64,
    parameter int GOOD_MAX     = 2,
    parameter int BAD_MIN      = 16,
    parameter int LOCK_CNT     = 4,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic            clk1,
    input  logic            rst_i,
    dpll_lock_ctrl_if.slave bus
);
    localparam int RW_W   = $clog2(N_TRK) + 2;
    localparam int ERR_W  = $clog2(WIN + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int SIL_W  = $clog2(LOSS_TIMEOUT + 1);

    localparam logic signed [RW_W-1:0] K_ACQ     = RW_W'(N_ACQ);
    localparam logic signed [RW_W-1:0] K_TRK     = RW_W'(N_TRK);
    localparam logic [ERR_W-1:0]       ERR_MAX   = ERR_W'(WIN);
    localparam logic [ERR_W-1:0]       EDGE_LAST = ERR_W'(WIN - 1);
    localparam logic [ERR_W-1:0]       GOOD_LIM  = ERR_W'(GOOD_MAX);
    localparam logic [ERR_W-1:0]       BAD_LIM   = ERR_W'(BAD_MIN);
    localparam logic [GOOD_W-1:0]      GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [SIL_W-1:0]       SIL_MAX   = SIL_W'(LOSS_TIMEOUT);
    localparam logic [SIL_W-1:0]       SIL_LAST  = SIL_W'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic signed [RW_W-1:0]  rw_reg, rw_next;
    logic [ERR_W-1:0]        err_reg, err_next;
    logic [ERR_W-1:0]        edge_reg, edge_next;
    logic [GOOD_W-1:0]       good_reg, good_next;
    logic [SIL_W-1:0]        sil_reg, sil_next;
    logic                    from_lock_reg, from_lock_next;
    logic                    carry_reg, carry_next;
    logic                    sub_reg, sub_next;
    logic [ERR_W-1:0]        win_err_reg, win_err_next;

    logic signed [RW_W-1:0]  k_sel;
    logic signed [RW_W-1:0]  step_v;
    logic signed [RW_W-1:0]  rw_sum;
    logic [ERR_W-1:0]        err_sum;
    logic                    win_close;
    logic                    timeout;

    // State register
    always_ff @(posedge clk1) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            rw_reg        <= '0;
            err_reg       <= '0;
            edge_reg      <= '0;
            good_reg      <= '0;
            sil_reg       <= '0;
            from_lock_reg <= 1'b0;
            carry_reg     <= 1'b0;
            sub_reg       <= 1'b0;
            win_err_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rw_reg        <= rw_next;
            err_reg       <= err_next;
            edge_reg      <= edge_next;
            good_reg      <= good_next;
            sil_reg       <= sil_next;
            from_lock_reg <= from_lock_next;
            carry_reg     <= carry_next;
            sub_reg       <= sub_next;
            win_err_reg   <= win_err_next;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_next     = state_reg;
        rw_next        = rw_reg;
        err_next       = err_reg;
        edge_next      = edge_reg;
        good_next      = good_reg;
        sil_next       = sil_reg;
        from_lock_next = from_lock_reg;
        carry_next     = 1'b0;
        sub_next       = 1'b0;
        win_err_next   = win_err_reg;

        k_sel = (state_reg == LOCK) ? K_TRK : K_ACQ;
        // Simultaneous lead and lag cancel in the walk but still count as an error.
        step_v = '0;
        if (bus.lead_i && !bus.lag_i) begin
            step_v = RW_W'(1);
        end else if (bus.lag_i && !bus.lead_i) begin
            step_v = '1;
        end
        rw_sum    = rw_reg + step_v;
        err_sum   = ((bus.lead_i || bus.lag_i) && (err_reg != ERR_MAX)) ?
                    err_reg + ERR_W'(1) : err_reg;
        win_close = bus.edge_i && (edge_reg == EDGE_LAST);
        timeout   = !bus.edge_i && (sil_reg == SIL_LAST);

        if (!bus.en_i) begin
            state_next     = IDLE;
            rw_next        = '0;
            err_next       = '0;
            edge_next      = '0;
            good_next      = '0;
            sil_next       = '0;
            from_lock_next = 1'b0;
        end else begin
            case (state_reg)
                ACQ, LOCK: begin
                    if (rw_sum == k_sel) begin
                        carry_next = 1'b1;
                        rw_next    = '0;
                    end else if (rw_sum == -k_sel) begin
                        sub_next = 1'b1;
                        rw_next  = '0;
                    end else begin
                        rw_next = rw_sum;
                    end

                    if (bus.edge_i) begin
                        sil_next = '0;
                    end else if (sil_reg != SIL_MAX) begin
                        sil_next = sil_reg + SIL_W'(1);
                    end

                    if (win_close) begin
                        win_err_next = err_sum;
                        err_next     = '0;
                        edge_next    = '0;
                        if (state_reg == ACQ) begin
                            if (err_sum <= GOOD_LIM) begin
                                if (good_reg == GOOD_LAST) begin
                                    state_next = LOCK;
                                end else begin
                                    good_next = good_reg + GOOD_W'(1);
                                end
                            end else begin
                                good_next = '0;
                            end
                        end else if (err_sum >= BAD_LIM) begin
                            state_next = ACQ;
                        end
                    end else begin
                        err_next = err_sum;
                        if (bus.edge_i) begin
                            edge_next = edge_reg + ERR_W'(1);
                        end
                    end

                    // Timeout needs a silent cycle, so it never collides with a window close.
                    if (timeout) begin
                        state_next     = HOLD;
                        from_lock_next = (state_reg == LOCK);
                    end

                    // A state change restarts the window bookkeeping; the walk
                    // value is kept frozen across holdover entry only. Any
                    // carry/sub decided above still goes out next cycle.
                    if (state_next != state_reg) begin
                        err_next  = '0;
                        edge_next = '0;
                        good_next = '0;
                        if (state_next != HOLD) begin
                            rw_next = '0;
                        end
                    end
                end
                HOLD: begin
                    // The returning edge is the first edge of the new window.
                    if (bus.edge_i) begin
                        state_next     = from_lock_reg ? LOCK : ACQ;
                        rw_next        = '0;
                        err_next       = '0;
                        edge_next      = ERR_W'(1);
                        good_next      = '0;
                        sil_next       = '0;
                        from_lock_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ACQ;
                    rw_next    = '0;
                    err_next   = '0;
                    edge_next  = '0;
                    good_next  = '0;
                    sil_next   = '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.carry_o   = carry_reg;
        bus.sub_o     = sub_reg;
        bus.lock_o    = (state_reg == LOCK);
        bus.hold_o    = (state_reg == HOLD);
        bus.state_o   = state_reg;
        bus.win_err_o = win_err_reg;
    end
endmodule
